serial_twos_comp: RTL and testbench

Serial two's-complementer (negator). A WIDTH-bit word is parallel-loaded, then shifted out LSB-first on output y as the serial two's complement of the loaded value. The block uses the copy-through-first-1-then-invert rule. It sits between a parallel data source and a serial consumer that samples y on each rising Clock edge while shifting is enabled.

---
 rtl/serial_twos_comp.sv | 46 ++++
 tb/tb_serial_twos_comp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_twos_comp.sv
// Serial two's-complementer: parallel-load a word, then shift out its
// negation LSB-first using the copy-through-first-1-then-invert rule.
module serial_twos_comp #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             shift_control,
  output logic             y
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic             seen_one_q;
  logic             seen_one_d;

  // Next-state selection: load wins over shift, otherwise hold.
  always_comb begin
    sr_d       = sr_q;
    seen_one_d = seen_one_q;
    if (load) begin
      sr_d       = data;
      seen_one_d = 1'b0;
    end else if (shift_control) begin
      sr_d       = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]};
      seen_one_d = seen_one_q | sr_q[0];
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      sr_q       <= '0;
      seen_one_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      seen_one_q <= seen_one_d;
    end
  end

  // Bits before the first 1 pass through; every bit after it is inverted.
  assign y = sr_q[0] ^ seen_one_q;

endmodule

// File: tb/tb_serial_twos_comp.sv
// Self-checking bench for serial_twos_comp with an expected-bit scoreboard.
module tb_serial_twos_comp;

  logic       Clock;
  logic       reset_b;
  logic [7:0] data;
  logic       load;
  logic       shift_control;
  logic       y;

  int checkCount = 0;
  int errorCount = 0;

  logic       expQ[$];
  logic [7:0] wordQ[$];

  serial_twos_comp #(.WIDTH(8)) dut (
    .Clock         (Clock),
    .reset_b       (reset_b),
    .data          (data),
    .load          (load),
    .shift_control (shift_control),
    .y             (y)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: bit k of the serial negation of d (k>=8 is extension).
  function automatic logic expBit(input logic [7:0] d, input int k);
    logic [7:0] neg;
    neg = 8'd0 - d;
    if (k < 8) return neg[k];
    return d[7] ^ (d != 8'd0);
  endfunction

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Drive a load (optionally with shift also high) and queue its expected bits.
  task automatic applyStimulus(input logic [7:0] d, input logic alsoShift);
    load = 1'b1;
    data = d;
    shift_control = alsoShift;
    tick();
    load = 1'b0;
    shift_control = 1'b0;
    expQ.delete();
    for (int k = 0; k < 9; k++) expQ.push_back(expBit(d, k));
    wordQ.push_back(8'd0 - d);
  endtask

  // Sample y before the shift edge, compare with the scoreboard, then shift.
  task automatic shiftSample(input string tag);
    if (expQ.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 32'd1, 32'd0);
    end else begin
      checkOutput(tag, {31'd0, y}, {31'd0, expQ.pop_front()});
    end
    shift_control = 1'b1;
    tick();
    shift_control = 1'b0;
  endtask

  task automatic runSequence(input string tag, input int n);
    for (int i = 0; i < n; i++) shiftSample($sformatf("%s_b%0d", tag, i));
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] word;

    reset_b = 1'b0;
    data = 8'h00;
    load = 1'b0;
    shift_control = 1'b0;
    @(negedge Clock);
    checkOutput("resetInit", {31'd0, y}, 32'd0);
    reset_b = 1'b1;
    tick();

    // Async reset with no clock edge: load FF so y=1 first.
    applyStimulus(8'hFF, 1'b0);
    checkOutput("preReset", {31'd0, y}, 32'd1);
    #2 reset_b = 1'b0;
    #1 checkOutput("asyncReset", {31'd0, y}, 32'd0);
    @(negedge Clock);
    checkOutput("resetHeld", {31'd0, y}, 32'd0);
    reset_b = 1'b1;
    expQ.delete();
    wordQ.delete();
    for (int i = 0; i < 3; i++) begin
      shift_control = 1'b1;
      tick();
      checkOutput($sformatf("postReset%0d", i), {31'd0, y}, 32'd0);
    end
    shift_control = 1'b0;

    // Basic negate and extremes, 9 samples each.
    applyStimulus(8'h0A, 1'b0); runSequence("neg0A", 9);
    applyStimulus(8'h00, 1'b0); runSequence("neg00", 9);
    applyStimulus(8'h80, 1'b0); runSequence("neg80", 9);
    applyStimulus(8'hFF, 1'b0); runSequence("negFF", 9);

    // Load and shift on the same edge: load wins, seen_one cleared.
    applyStimulus(8'hFF, 1'b0); runSequence("prioPre", 3);
    applyStimulus(8'h0A, 1'b1); runSequence("prio0A", 9);

    // Hold mid-sequence, then resume.
    applyStimulus(8'h0A, 1'b0); runSequence("holdA", 3);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("hold%0d", i), {31'd0, y}, {31'd0, expQ[0]});
    end
    runSequence("holdB", 6);

    // Reload mid-shift restarts the sequence.
    applyStimulus(8'h0A, 1'b0); runSequence("reloadPre", 3);
    applyStimulus(8'h03, 1'b0); runSequence("reload03", 9);

    // Reset pulse mid-shift, then check no stale seen_one after next load.
    applyStimulus(8'h0A, 1'b0); runSequence("rstMidPre", 3);
    #2 reset_b = 1'b0;
    #1 checkOutput("rstMid", {31'd0, y}, 32'd0);
    @(negedge Clock);
    reset_b = 1'b1;
    applyStimulus(8'h04, 1'b0); runSequence("rstMid04", 9);

    // Randomised: collect 8 bits and compare against the queued word.
    wordQ.delete();
    for (int n = 0; n < 200; n++) begin
      r = 8'($urandom_range(0, 255));
      applyStimulus(r, 1'b0);
      word = 8'h00;
      for (int k = 0; k < 8; k++) begin
        word[k] = y;
        void'(expQ.pop_front());
        shift_control = 1'b1;
        tick();
        shift_control = 1'b0;
      end
      if (wordQ.size() == 0) checkOutput("randSbEmpty", 32'd1, 32'd0);
      else checkOutput($sformatf("rand%0d_d%02h", n, r), {24'd0, word}, {24'd0, wordQ.pop_front()});
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
